// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: datapath widths, base opcodes and immediate formats.
// Helper functions classify an opcode so the decode and later stages agree.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic logic opcode_legal(input logic [6:0] opcode);
        return opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                              OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE,
                              OPC_SYSTEM};
    endfunction

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        case (opcode)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE, OPC_SYSTEM: return IMM_I;
            OPC_STORE:                                             return IMM_S;
            OPC_BRANCH:                                            return IMM_B;
            OPC_LUI, OPC_AUIPC:                                    return IMM_U;
            OPC_JAL:                                               return IMM_J;
            default:                                               return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator: selects the format from the opcode and
// builds the sign-extended immediate. R-type and unknown opcodes yield zero.
module rv32i_imm_gen #(
    parameter int XLEN = rv32i_pkg::XLEN
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);
    import rv32i_pkg::*;

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_fmt(instr[6:0]))
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode / operand-fetch stage: register reads with WB bypass, field and
// immediate decode, load-use bubble insertion, and the ID/EX pipeline register.
module rv32i_decode_stage #(
    parameter int XLEN   = rv32i_pkg::XLEN,
    parameter int REG_AW = rv32i_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_imm,
    output logic [6:0]        ex_opcode,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic              ex_rd_we,
    output logic              ex_is_load,
    output logic              ex_illegal
);
    import rv32i_pkg::*;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   imm, op1, op2;
    logic              use_rs1, use_rs2, legal, rd_we;
    logic              hazard, advance;

    assign opcode    = if_instr[6:0];
    assign rs1       = REG_AW'(if_instr[19:15]);
    assign rs2       = REG_AW'(if_instr[24:20]);
    assign rd        = REG_AW'(if_instr[11:7]);
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    rv32i_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // The register file returns pre-write data, so forward the WB write here.
    always_comb begin
        op1 = rf_rdata1;
        if (rs1 == '0)                      op1 = '0;
        else if (wb_we && (wb_rd == rs1))   op1 = wb_data;
        op2 = rf_rdata2;
        if (rs2 == '0)                      op2 = '0;
        else if (wb_we && (wb_rd == rs2))   op2 = wb_data;
    end

    assign use_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign use_rs2 = opcode inside {OPC_STORE, OPC_BRANCH, OPC_OP};
    assign legal   = opcode_legal(opcode);
    assign rd_we   = legal && !(opcode inside {OPC_STORE, OPC_BRANCH, OPC_FENCE})
                     && (rd != '0);

    assign hazard   = ex_valid && ex_is_load && (ex_rd != '0) &&
                      ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    assign advance  = !ex_valid || ex_ready;
    assign if_ready = flush || (advance && !hazard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_imm      <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_rd_we    <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush || (advance && hazard)) begin
            ex_valid   <= 1'b0;
            ex_rd_we   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (advance) begin
            ex_valid    <= if_valid;
            ex_pc       <= if_pc;
            ex_rs1_data <= op1;
            ex_rs2_data <= op2;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            ex_imm      <= imm;
            ex_opcode   <= opcode;
            ex_funct3   <= if_instr[14:12];
            ex_funct7b5 <= if_instr[30];
            ex_rd_we    <= if_valid && rd_we;
            ex_is_load  <= if_valid && (opcode == OPC_LOAD);
            ex_illegal  <= if_valid && !legal;
        end
    end

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- Instruction-decode / operand-fetch stage of the RV32I pipeline; sits between fetch and execute.
- Drives the register file's two asynchronous read ports and applies a WB-stage write bypass, because the file returns pre-write data in the same cycle.
- Decodes fields and immediates, detects load-use hazards, and holds results in the ID/EX pipeline register under a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- rf_raddr1  out  REG_AW  register-file read address 1 = if_instr[19:15]
- rf_raddr2  out  REG_AW  register-file read address 2 = if_instr[24:20]
- rf_rdata1  in  XLEN  register-file read data 1
- rf_rdata2  in  XLEN  register-file read data 2
- wb_we  in  1  writeback write enable (same signal that feeds the register file)
- wb_rd  in  REG_AW  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  kill from EX (branch/jump redirect)
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  EX consumes this cycle
- ex_pc  out  XLEN  registered PC
- ex_rs1_data  out  XLEN  registered operand 1
- ex_rs2_data  out  XLEN  registered operand 2
- ex_rs1  out  REG_AW  registered source 1 address
- ex_rs2  out  REG_AW  registered source 2 address
- ex_rd  out  REG_AW  registered destination
- ex_imm  out  XLEN  sign-extended immediate
- ex_opcode  out  7  opcode
- ex_funct3  out  3  funct3
- ex_funct7b5  out  1  instr[30]
- ex_rd_we  out  1  instruction writes rd
- ex_is_load  out  1  opcode LOAD
- ex_illegal  out  1  opcode not in the RV32I set

Behaviour:
- Reset (reset=0, asynchronous): every ex_* output goes to 0, including ex_valid=0. Mid-operation reset drops the held instruction.
- rf_raddr1/2 are combinational from if_instr, independent of if_valid.
- Operand selection, per source: rs==0 → 0; else wb_we && wb_rd==rs → wb_data; else rf_rdata.
- Latency: one cycle from accept to ex_valid.
- advance = !ex_valid || ex_ready.
- Uses of sources:
  - rs1 is used unless the opcode is LUI, AUIPC or JAL.
  - rs2 is used for STORE, BRANCH and OP.
- hazard = ex_valid && ex_is_load && ex_rd!=0 && (used rs1==ex_rd || used rs2==ex_rd) on if_instr.
- if_ready = flush || (advance && !hazard).
- Register update, in priority order:
  - flush: ex_valid<=0 next edge; the fetch word is consumed and discarded.
  - else advance && hazard: ex_valid<=0, a bubble. Exactly one bubble per load-use; the following cycle accepts.
  - else advance: ex_valid<=if_valid, all fields loaded.
  - else (stalled by EX): all ex_* outputs hold stable.
- While ex_valid=1 && ex_ready=0, outputs must not change.
- Immediates:
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25],instr[11:7]} sign-extended.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - OP: 0.
- ex_rd_we=1 except for STORE, BRANCH, FENCE, illegal, or rd==0.
- Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM.
- Illegal opcode: ex_illegal=1, ex_rd_we=0, still passed downstream with ex_valid=1.
- Bubbles carry ex_rd_we=0 and ex_is_load=0.

Decomposition:
- Shared package rv32i_pkg: opcode localparams, immediate-format enum (IMM_I/S/B/U/J/NONE), XLEN/REG_AW constants.
- One combinational sub-module rv32i_imm_gen (instr → imm), reused by later stages.

Test Plan:
- Reset, then ADDI x5,x0,-1 (0xFFF00293) with ex_ready=1 → next cycle ex_valid=1, ex_rd=5, ex_imm=0xFFFFFFFF, ex_rd_we=1; ex_rs1_data=0 even if rf_rdata1=0x1234.
- ADD x3,x1,x2 with rf_rdata1=0x10, wb_we=1, wb_rd=1, wb_data=0xABCD → ex_rs1_data=0xABCD; with wb_rd=0 the bypass is ignored.
- LW x7,0(x1) accepted, then ADD x8,x7,x2 presented → if_ready=0 for one cycle, one bubble (ex_valid=0), ADD issued on the following cycle.
- ex_ready=0 for 3 cycles with SW in ID/EX → outputs stable, if_ready=0, ex_rd_we=0; release → next instruction advances.
- flush while ex_ready=0 and if_valid=1 → ex_valid=0 next cycle, if_ready=1, fetched word discarded.
- Opcode 0x7F → ex_illegal=1, ex_rd_we=0. Assert reset mid-stall → ex_valid=0 immediately (asynchronous).
